// File: rtl/axis_keep_packer.sv
// axis_keep_packer
//   Repacks sparse AXI-Stream beats (per-word tkeep) into dense OUT_WORDS-wide beats.
//   Kept words are appended in order to an internal buffer. A beat is emitted whenever
//   OUT_WORDS words are buffered. At packet end a final partial beat carries tlast.
// Ports
//   aclk, areset           clock, synchronous active-high reset
//   s_axis_tvalid/tready   input handshake
//   s_axis_tdata/tkeep     IN_WORDS words, tkeep[i]=1 keeps word i
//   s_axis_tlast           last input beat of packet
//   m_axis_tvalid/tready   output handshake
//   m_axis_tdata/tkeep     OUT_WORDS dense words, tkeep contiguous from bit 0
//   m_axis_tlast           final output beat of packet
module axis_keep_packer #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned IN_WORDS   = 12,
    parameter int unsigned OUT_WORDS  = 8
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [IN_WORDS*WORD_WIDTH-1:0]   s_axis_tdata,
    input  logic [IN_WORDS-1:0]              s_axis_tkeep,
    input  logic                             s_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [OUT_WORDS*WORD_WIDTH-1:0]  m_axis_tdata,
    output logic [OUT_WORDS-1:0]             m_axis_tkeep,
    output logic                             m_axis_tlast
);

    localparam int unsigned BUF_WORDS = OUT_WORDS + IN_WORDS - 1;
    localparam int unsigned CNT_W     = $clog2(BUF_WORDS + 1);
    localparam logic [CNT_W-1:0]     OUT_CNT  = CNT_W'(OUT_WORDS);
    localparam logic [OUT_WORDS-1:0] KEEP_ONE = OUT_WORDS'(1);

    typedef enum logic [1:0] {ModeFill, ModeFull, ModeFlush} mode_e;

    logic [WORD_WIDTH-1:0] buf_q [BUF_WORDS];
    logic [WORD_WIDTH-1:0] buf_d [BUF_WORDS];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  last_pending_q, last_pending_d;
    mode_e                 mode;

    // Mode depends on registered state only, so s_axis_tready never depends on m_axis_tready.
    always_comb begin
        mode = ModeFill;
        if (count_q >= OUT_CNT) begin
            mode = ModeFull;
        end else if (last_pending_q) begin
            mode = ModeFlush;
        end
    end

    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        for (int i = 0; i < OUT_WORDS; i++) begin
            m_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH] = buf_q[i];
        end
        unique case (mode)
            ModeFill: begin
                s_axis_tready = 1'b1;
            end
            ModeFull: begin
                m_axis_tvalid = 1'b1;
                m_axis_tkeep  = '1;
            end
            ModeFlush: begin
                m_axis_tvalid = 1'b1;
                // count_q < OUT_WORDS here, so the mask never overflows.
                m_axis_tkeep  = (KEEP_ONE << count_q) - KEEP_ONE;
                m_axis_tlast  = 1'b1;
            end
            default: begin
                s_axis_tready = 1'b0;
            end
        endcase
    end

    always_comb begin
        logic [CNT_W-1:0] wr_idx;
        buf_d          = buf_q;
        count_d        = count_q;
        last_pending_d = last_pending_q;
        wr_idx         = count_q;
        unique case (mode)
            ModeFill: begin
                if (s_axis_tvalid) begin
                    // Compact kept words: each lands after all earlier kept words.
                    for (int i = 0; i < IN_WORDS; i++) begin
                        if (s_axis_tkeep[i]) begin
                            buf_d[wr_idx] = s_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH];
                            wr_idx        = wr_idx + CNT_W'(1);
                        end
                    end
                    count_d        = wr_idx;
                    last_pending_d = last_pending_q | s_axis_tlast;
                end
            end
            ModeFull: begin
                if (m_axis_tready) begin
                    for (int j = 0; j < BUF_WORDS - OUT_WORDS; j++) begin
                        buf_d[j] = buf_q[j + OUT_WORDS];
                    end
                    count_d = count_q - OUT_CNT;
                end
            end
            ModeFlush: begin
                if (m_axis_tready) begin
                    count_d        = '0;
                    last_pending_d = 1'b0;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            count_q        <= '0;
            last_pending_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            last_pending_q <= last_pending_d;
        end
        buf_q <= buf_d;
    end

endmodule
